lc3_mem_responder: RTL and testbench

//  Memory-side responder for the LC-3 datapath's MAR/MDR bus interface. It

---
 rtl/lc3_mem_responder_pkg.sv | 19 +
 rtl/lc3_mem_array.sv | 24 ++
 rtl/lc3_mem_responder.sv | 110 +++++++++++
 tb/tb_lc3_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_responder_pkg.sv
// lc3_mem_responder_pkg: shared console-register addresses, FSM states and MMIO decode helper
//   MMIO_BASE / KBSR_ADDR / KBDR_ADDR / DSR_ADDR / DDR_ADDR : memory-mapped console map
//   state_t : access FSM states
//   is_mmio : 1 when an address falls in the console window xFE00..xFFFF
package lc3_mem_responder_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

    function automatic logic is_mmio(input logic [15:0] a);
        return a >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: single-port synchronous RAM, one-cycle read latency, contents not reset
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data of addr from the previous edge
module lc3_mem_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 MAR/MDR memory responder with backing RAM and console registers
//   clk, rst (async, active-low)
//   mar, mdr_wdata, mio_en, r_w   : access request from the datapath
//   mem_rdata, ready              : read data and one-cycle completion pulse
//   kbd_valid, kbd_data, kbd_ready    : keyboard source handshake (KBSR/KBDR)
//   disp_valid, disp_data, disp_ready : display sink handshake (DSR/DDR)
module lc3_mem_responder
    import lc3_mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int MEM_AW      = 12,
    parameter int MMIO_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_wdata,
    input  logic        mio_en,
    input  logic        r_w,
    output logic [15:0] mem_rdata,
    output logic        ready,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] mar_q;
    logic [15:0] wdata_q;
    logic        rw_q;
    logic        kbsr;
    logic [7:0]  kbdr;
    logic [15:0] ram_rdata;
    logic [15:0] mmio_rdata;
    logic        finish;
    logic        mmio_q;
    logic        ram_we;
    logic [MEM_AW-1:0] ram_addr;

    assign finish    = state == BUSY && cnt == 16'd0;
    assign mmio_q    = is_mmio(mar_q);
    assign ram_we    = finish && rw_q && !mmio_q;
    assign kbd_ready = ~kbsr;

    // The RAM sees the live mar in IDLE so a one-cycle latency still has data by DONE.
    assign ram_addr = state == IDLE ? mar[MEM_AW-1:0] : mar_q[MEM_AW-1:0];

    // DSR[15] is exactly "no display character pending", so it is derived from disp_valid.
    assign mmio_rdata = mar_q == KBSR_ADDR ? {kbsr, 15'b0} :
                        mar_q == KBDR_ADDR ? {8'b0, kbdr} :
                        mar_q == DSR_ADDR  ? {~disp_valid, 15'b0} : 16'h0000;

    lc3_mem_array #(.AW(MEM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            mar_q      <= 16'h0000;
            wdata_q    <= 16'h0000;
            rw_q       <= 1'b0;
            ready      <= 1'b0;
            mem_rdata  <= 16'h0000;
            kbsr       <= 1'b0;
            kbdr       <= 8'h00;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            ready <= finish;
            case (state)
                IDLE: if (mio_en) begin
                    mar_q   <= mar;
                    wdata_q <= mdr_wdata;
                    rw_q    <= r_w;
                    cnt     <= is_mmio(mar) ? 16'(MMIO_WAIT - 1) : 16'(WAIT_CYCLES - 1);
                    state   <= BUSY;
                end
                BUSY:    if (cnt == 16'd0) state <= DONE; else cnt <= cnt - 16'd1;
                DONE:    state <= RELEASE;
                RELEASE: if (!mio_en) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (finish && !rw_q) mem_rdata <= mmio_q ? mmio_rdata : ram_rdata;
            // A keyboard arrival on the same edge as a KBDR-read clear wins.
            if (kbd_valid && !kbsr) begin
                kbdr <= kbd_data;
                kbsr <= 1'b1;
            end else if (finish && !rw_q && mar_q == KBDR_ADDR) begin
                kbsr <= 1'b0;
            end
            if (finish && rw_q && mar_q == DDR_ADDR && !disp_valid) begin
                disp_data  <= wdata_q[7:0];
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: scoreboard bench for lc3_mem_responder against a behavioural model
module tb_lc3_mem_responder;

    localparam int WC = 4;
    localparam int AW = 12;
    localparam int MW = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mar = 16'h0;
    logic [15:0] mdr_wdata = 16'h0;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mem_rdata;
    logic        ready;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h0;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;

    lc3_mem_responder #(.WAIT_CYCLES(WC), .MEM_AW(AW), .MMIO_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mar        (mar),
        .mdr_wdata  (mdr_wdata),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mem_rdata  (mem_rdata),
        .ready      (ready),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        bit          chk;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Behavioural model: RAM as a sparse map keyed by aliased word address, console as flags.
    logic [15:0] mram [int];
    bit          kb_full;
    logic [7:0]  kb_char;
    bit          d_pend;
    logic [7:0]  d_char;
    logic [15:0] last_rd;
    bit          last_known;

    task automatic model_reset();
        kb_full    = 0;
        kb_char    = 8'h00;
        d_pend     = 0;
        d_char     = 8'h00;
        last_rd    = 16'h0000;
        last_known = 1;
    endtask

    task automatic model_access(input logic [15:0] a, input bit w, input logic [15:0] d,
                                output logic [15:0] ed, output bit ec, output int lat);
        int idx;
        idx = int'(a) % (1 << AW);
        if (a < 16'hFE00) begin
            lat = WC;
            if (w) mram[idx] = d;
            else if (mram.exists(idx)) begin
                last_rd    = mram[idx];
                last_known = 1;
            end else last_known = 0;
        end else begin
            lat = MW;
            if (!w) begin
                last_known = 1;
                if (a == 16'hFE00) last_rd = kb_full ? 16'h8000 : 16'h0000;
                else if (a == 16'hFE02) begin
                    last_rd = {8'h00, kb_char};
                    kb_full = 0;
                end else if (a == 16'hFE04) last_rd = d_pend ? 16'h0000 : 16'h8000;
                else last_rd = 16'h0000;
            end else if (a == 16'hFE06 && !d_pend) begin
                d_pend = 1;
                d_char = d[7:0];
            end
        end
        ed = last_rd;
        ec = last_known;
    endtask

    // Monitor: every ready pulse must match the oldest outstanding access.
    logic prev_ready = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_ready) check("ready_width", {15'b0, ready}, 16'h0000);
            if (ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: ready=1 with no access outstanding, want 0");
                end else begin
                    mon_e = q.pop_front();
                    check_int("latency", cyc, mon_e.due);
                    if (mon_e.chk) check("rdata", mem_rdata, mon_e.data);
                end
            end
        end
        prev_ready = ready;
    end

    task automatic access(input logic [15:0] a, input bit w, input logic [15:0] d, input int hold);
        logic [15:0] ed;
        bit          ec;
        int          lat;
        int          n;
        @(negedge clk);
        mar = a;
        mdr_wdata = d;
        r_w = w;
        mio_en = 1'b1;
        model_access(a, w, d, ed, ec, lat);
        q.push_back('{ed, ec, cyc + 1 + lat});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no ready for addr %h, want ready within 100 cycles", a);
            q.delete();
        end
        repeat (hold) @(negedge clk);
        mio_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic kbd_push(input logic [7:0] d);
        @(negedge clk);
        kbd_valid = 1'b1;
        kbd_data = d;
        if (!kb_full) begin
            kb_full = 1;
            kb_char = d;
        end
        @(negedge clk);
        kbd_valid = 1'b0;
        check("kbd_ready", {15'b0, kbd_ready}, {15'b0, ~kb_full});
    endtask

    task automatic disp_pulse();
        @(negedge clk);
        disp_ready = 1'b1;
        d_pend = 0;
        @(negedge clk);
        disp_ready = 1'b0;
        check("disp_valid", {15'b0, disp_valid}, {15'b0, d_pend});
    endtask

    task automatic check_console(input string tag);
        check({tag, "_kbd_ready"}, {15'b0, kbd_ready}, {15'b0, ~kb_full});
        check({tag, "_disp_valid"}, {15'b0, disp_valid}, {15'b0, d_pend});
        if (d_pend) check({tag, "_disp_data"}, {8'b0, disp_data}, {8'b0, d_char});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {15'b0, ready}, 16'h0000);
        check("rst_mem_rdata", mem_rdata, 16'h0000);
        check("rst_kbd_ready", {15'b0, kbd_ready}, 16'h0001);
        check("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check("rst_disp_data", {8'b0, disp_data}, 16'h0000);

        access(16'h3000, 1, 16'h1234, 0);
        access(16'h3000, 0, 16'h0000, 0);

        access(16'h3000, 0, 16'h0000, 3);
        access(16'h3001, 1, 16'hA5A5, 0);
        access(16'h3001, 0, 16'h0000, 0);

        kbd_push(8'h41);
        access(16'hFE00, 0, 16'h0000, 0);
        access(16'hFE02, 0, 16'h0000, 0);
        access(16'hFE00, 0, 16'h0000, 0);
        check_console("kbd");

        access(16'hFE06, 1, 16'h0048, 0);
        check_console("ddr1");
        access(16'hFE04, 0, 16'h0000, 0);
        access(16'hFE06, 1, 16'h0049, 0);
        check_console("ddr2");
        disp_pulse();
        access(16'hFE04, 0, 16'h0000, 0);

        access(16'h1005, 1, 16'hBEEF, 0);
        access(16'h0005, 0, 16'h0000, 0);
        access(16'hFE10, 0, 16'h0000, 0);
        access(16'hFFFF, 1, 16'h1111, 0);

        access(16'h0100, 1, 16'h0777, 0);
        access(16'hFE06, 1, 16'h0033, 0);
        @(negedge clk);
        mar = 16'h0100;
        mdr_wdata = 16'h5555;
        r_w = 1'b1;
        mio_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mio_en = 1'b0;
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_console("abort");
        check("abort_mem_rdata", mem_rdata, 16'h0000);
        access(16'hFE04, 0, 16'h0000, 0);
        access(16'h0100, 0, 16'h0000, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: kbd_push(8'($urandom));
                1: disp_pulse();
                2, 3: begin
                    a = 16'hFE00 + 16'($urandom_range(0, 8));
                    access(a, 1'($urandom), 16'($urandom), $urandom_range(0, 2));
                end
                default: begin
                    a = 16'(($urandom_range(0, 14) << 12) | $urandom_range(0, 31));
                    access(a, 1'($urandom), 16'($urandom), $urandom_range(0, 2));
                end
            endcase
        end
        check_console("final");
        repeat (3) @(negedge clk);
        check_int("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
